pipe_ctrl: RTL and testbench

Parametrised pipeline controller for the CPU core; supersedes the single-cycle combinational stall/flush controller. Merges per-stage stall requests into a thermometer stall mask over STAGES stages. Sequences exception handling through a registered FLUSH -> REDIRECT state machine with a fetch-side valid/ready handshake for the new PC. Sits beside the pipeline registers; drives their stall and flush inputs and the PC register's redirect input.

---
 rtl/pipe_ctrl_pkg.sv | 59 +++++
 rtl/pipe_ctrl_stall_mask_gen.sv | 14 +
 rtl/pipe_ctrl.sv | 128 ++++++++++++
 tb/tb_pipe_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared CPU definitions: exception codes, vector addresses, controller states
// and the exception-to-vector lookup used by pipe_ctrl.
package cpu_defines;

    typedef logic [31:0] Word_t;
    typedef logic [31:0] Inst_addr_t;

    typedef enum logic [3:0] {
        EXC_NO               = 4'd0,
        EXC_INTERRUPT        = 4'd1,
        EXC_SYSCALL          = 4'd2,
        EXC_INVALID_INST     = 4'd3,
        EXC_OV               = 4'd4,
        EXC_ERET             = 4'd5,
        EXC_INST_TLB_REFILL  = 4'd6,
        EXC_DATA_TLB_REFILL  = 4'd7,
        EXC_INST_TLB_INVALID = 4'd8,
        EXC_DATA_TLB_INVALID = 4'd9,
        EXC_BREAK            = 4'd10
    } Excp_t;

    typedef enum logic [1:0] {
        CTRL_IDLE     = 2'd0,
        CTRL_FLUSH    = 2'd1,
        CTRL_REDIRECT = 2'd2
    } Ctrl_state_t;

    typedef struct packed {
        logic       valid;
        Inst_addr_t pc;
    } Excp_vec_t;

    localparam Inst_addr_t PC_RESET_ADDR   = 32'hBFC0_0000;
    localparam Inst_addr_t PC_TLB_REFILL   = 32'hBFC0_0200;
    localparam Inst_addr_t PC_SYSCALL      = 32'hBFC0_0380;
    localparam Inst_addr_t PC_INVALID_INST = 32'hBFC0_0384;
    localparam Inst_addr_t PC_OV           = 32'hBFC0_0388;
    localparam Inst_addr_t PC_TLB_INVALID  = 32'hBFC0_038C;
    localparam Inst_addr_t PC_INTERRUPT    = 32'hBFC0_0400;

    // Codes without a vector (e.g. EXC_BREAK) come back invalid and are ignored.
    function automatic Excp_vec_t excp_vector(input Excp_t excp, input Word_t epc);
        Excp_vec_t r;
        r.valid = 1'b1;
        r.pc    = PC_RESET_ADDR;
        case (excp)
            EXC_INTERRUPT:                              r.pc = PC_INTERRUPT;
            EXC_SYSCALL:                                r.pc = PC_SYSCALL;
            EXC_INVALID_INST:                           r.pc = PC_INVALID_INST;
            EXC_OV:                                     r.pc = PC_OV;
            EXC_INST_TLB_REFILL, EXC_DATA_TLB_REFILL:   r.pc = PC_TLB_REFILL;
            EXC_INST_TLB_INVALID, EXC_DATA_TLB_INVALID: r.pc = PC_TLB_INVALID;
            EXC_ERET:                                   r.pc = epc;
            default:                                    r.valid = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_mask_gen.sv
// Priority-to-thermometer stall mask: a stall at stage h also stalls every
// stage below it. Purely combinational.
module stall_mask_gen #(
    parameter int STAGES = 6
) (
    input  logic [STAGES-1:0] stallreq_i,
    output logic [STAGES-1:0] mask_o
);

    for (genvar k = 0; k < STAGES; k++) begin : g_mask
        assign mask_o[k] = |stallreq_i[STAGES-1:k];
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with a FLUSH -> REDIRECT exception sequencer.
// Optional stall watchdog enabled by defining PIPE_CTRL_STALL_WATCHDOG_EN.
module pipe_ctrl
    import cpu_defines::*;
#(
    parameter int STAGES       = 6,
    parameter int FLUSH_CYCLES = 1,
    parameter int WDOG_LIMIT   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STAGES-1:0] stallreq_i,
    input  Excp_t             exception_type_i,
    input  Word_t             cp0_epc_i,
    input  logic              fetch_ready_i,
    output logic [STAGES-1:0] stall_o,
    output logic              flush_o,
    output Inst_addr_t        new_pc_o,
    output logic              redirect_valid_o,
    output logic              busy_o,
    output logic              stall_timeout_o
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [FC_W-1:0] FLUSH_LOAD = FC_W'(FLUSH_CYCLES - 1);

    Ctrl_state_t       state_d, state_q;
    Inst_addr_t        new_pc_d, new_pc_q;
    logic [FC_W-1:0]   flush_cnt_d, flush_cnt_q;
    logic              flush_d, flush_q;
    logic              redirect_valid_d, redirect_valid_q;
    logic              busy_d, busy_q;
    logic [STAGES-1:0] mask;
    Excp_vec_t         vec;
    logic              capture;

    stall_mask_gen #(.STAGES(STAGES)) u_stall_mask_gen (
        .stallreq_i (stallreq_i),
        .mask_o     (mask)
    );

    assign vec     = excp_vector(exception_type_i, cp0_epc_i);
    // Exceptions arriving while a flush is already in progress are dropped.
    assign capture = vec.valid && (state_q != CTRL_FLUSH);

    always_comb begin
        state_d     = state_q;
        new_pc_d    = new_pc_q;
        flush_cnt_d = flush_cnt_q;
        stall_o     = '0;
        case (state_q)
            CTRL_IDLE: stall_o = mask;
            CTRL_FLUSH: begin
                if (flush_cnt_q == '0) state_d = CTRL_REDIRECT;
                else                   flush_cnt_d = flush_cnt_q - 1'b1;
            end
            CTRL_REDIRECT: begin
                stall_o = mask | STAGES'(1);
                if (fetch_ready_i) state_d = CTRL_IDLE;
            end
            default: state_d = CTRL_IDLE;
        endcase
        // Capture beats both stall requests and a simultaneous fetch handshake.
        if (capture) begin
            stall_o     = '0;
            new_pc_d    = vec.pc;
            flush_cnt_d = FLUSH_LOAD;
            state_d     = CTRL_FLUSH;
        end
        if (rst) stall_o = '0;
        flush_d          = (state_d == CTRL_FLUSH);
        redirect_valid_d = (state_d == CTRL_REDIRECT);
        busy_d           = (state_d != CTRL_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= CTRL_IDLE;
            new_pc_q         <= PC_RESET_ADDR;
            flush_cnt_q      <= '0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            busy_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            new_pc_q         <= new_pc_d;
            flush_cnt_q      <= flush_cnt_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            busy_q           <= busy_d;
        end
    end

    assign flush_o          = flush_q;
    assign redirect_valid_o = redirect_valid_q;
    assign busy_o           = busy_q;
    assign new_pc_o         = new_pc_q;

`ifdef PIPE_CTRL_STALL_WATCHDOG_EN
    localparam int WD_W = $clog2(WDOG_LIMIT + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(WDOG_LIMIT);

    logic [WD_W-1:0] wd_cnt_d, wd_cnt_q;
    logic            timeout_d, timeout_q;

    always_comb begin
        wd_cnt_d = '0;
        if (state_q == CTRL_IDLE && stall_o != '0)
            wd_cnt_d = (wd_cnt_q == WD_MAX) ? wd_cnt_q : wd_cnt_q + 1'b1;
        timeout_d = timeout_q | (wd_cnt_d == WD_MAX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_cnt_q  <= wd_cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign stall_timeout_o = timeout_q;
`else
    assign stall_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl (STAGES=6, FLUSH_CYCLES=2, WDOG_LIMIT=8).
// The watchdog scenario follows PIPE_CTRL_STALL_WATCHDOG_EN.
module tb_pipe_ctrl;
    import cpu_defines::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] stallreq_i = '0;
    Excp_t      exception_type_i = EXC_NO;
    Word_t      cp0_epc_i = '0;
    logic       fetch_ready_i = 1'b0;
    logic [5:0] stall_o;
    logic       flush_o;
    Inst_addr_t new_pc_o;
    logic       redirect_valid_o;
    logic       busy_o;
    logic       stall_timeout_o;

    int checks = 0;
    int errors = 0;

    pipe_ctrl #(.STAGES(6), .FLUSH_CYCLES(2), .WDOG_LIMIT(8)) dut (
        .clk              (clk),
        .rst              (rst),
        .stallreq_i       (stallreq_i),
        .exception_type_i (exception_type_i),
        .cp0_epc_i        (cp0_epc_i),
        .fetch_ready_i    (fetch_ready_i),
        .stall_o          (stall_o),
        .flush_o          (flush_o),
        .new_pc_o         (new_pc_o),
        .redirect_valid_o (redirect_valid_o),
        .busy_o           (busy_o),
        .stall_timeout_o  (stall_timeout_o)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge; inputs are driven here and
    // outputs are sampled at the following falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stallreq_i = 6'($urandom);
            tick();
            @(negedge clk);
            checks++;
            if ({stall_o, flush_o, redirect_valid_o, busy_o, stall_timeout_o} !== 10'b0) begin
                errors++;
                $display("FAIL reset_outputs cyc%0d: stall=%b fl=%b rv=%b busy=%b to=%b, need all 0",
                         i, stall_o, flush_o, redirect_valid_o, busy_o, stall_timeout_o);
            end
            checks++;
            if (new_pc_o !== PC_RESET_ADDR) begin
                errors++;
                $display("FAIL reset_pc: got %h need %h", new_pc_o, PC_RESET_ADDR);
            end
        end
        tick();
        rst = 1'b0;
        stallreq_i = '0;
    endtask

    task automatic test_stall_mask();
        logic [5:0] req [4] = '{6'b000100, 6'b100000, 6'b100100, 6'b000000};
        logic [5:0] exp [4] = '{6'b000111, 6'b111111, 6'b111111, 6'b000000};
        for (int i = 0; i < 4; i++) begin
            tick();
            stallreq_i = req[i];
            @(negedge clk);
            checks++;
            if (stall_o !== exp[i]) begin
                errors++;
                $display("FAIL stall_mask req=%b: got %b need %b", req[i], stall_o, exp[i]);
            end
        end
        // An unmapped exception code is ignored entirely.
        tick();
        stallreq_i = 6'b001000;
        exception_type_i = EXC_BREAK;
        @(negedge clk);
        checks++;
        if (stall_o !== 6'b001111) begin
            errors++;
            $display("FAIL unmapped_exc_stall: got %b need 001111", stall_o);
        end
        tick();
        exception_type_i = EXC_NO;
        stallreq_i = '0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || flush_o !== 1'b0) begin
            errors++;
            $display("FAIL unmapped_exc_idle: busy=%b flush=%b need 0 0", busy_o, flush_o);
        end
    endtask

    task automatic test_syscall();
        // cycle 0 = capture; flush +1..+2; redirect from +3; ready at +5.
        tick();
        stallreq_i = 6'b100000;
        exception_type_i = EXC_SYSCALL;
        @(negedge clk);
        checks++;
        if (stall_o !== 6'b000000) begin
            errors++;
            $display("FAIL syscall_capture_stall: got %b need 000000", stall_o);
        end
        for (int c = 1; c <= 6; c++) begin
            tick();
            exception_type_i = EXC_NO;
            stallreq_i = (c == 4) ? 6'b000000 : 6'b100000;
            fetch_ready_i = (c == 5);
            @(negedge clk);
            checks++;
            if (flush_o !== (c <= 2)) begin
                errors++;
                $display("FAIL syscall_flush c+%0d: got %b need %b", c, flush_o, (c <= 2));
            end
            checks++;
            if (redirect_valid_o !== (c >= 3 && c <= 5)) begin
                errors++;
                $display("FAIL syscall_rv c+%0d: got %b need %b", c, redirect_valid_o, (c >= 3 && c <= 5));
            end
            checks++;
            if (busy_o !== (c <= 5)) begin
                errors++;
                $display("FAIL syscall_busy c+%0d: got %b need %b", c, busy_o, (c <= 5));
            end
            if (c >= 3) begin
                checks++;
                if (new_pc_o !== PC_SYSCALL) begin
                    errors++;
                    $display("FAIL syscall_pc c+%0d: got %h need %h", c, new_pc_o, PC_SYSCALL);
                end
            end
            if (c <= 2) begin
                checks++;
                if (stall_o !== 6'b000000) begin
                    errors++;
                    $display("FAIL syscall_flush_stall c+%0d: got %b need 000000", c, stall_o);
                end
            end
            if (c == 3 || c == 4) begin
                checks++;
                if (stall_o !== ((c == 3) ? 6'b111111 : 6'b000001)) begin
                    errors++;
                    $display("FAIL syscall_redirect_stall c+%0d: got %b", c, stall_o);
                end
            end
        end
        stallreq_i = '0;
        fetch_ready_i = 1'b0;
    endtask

    task automatic test_eret();
        tick();
        exception_type_i = EXC_ERET;
        cp0_epc_i = 32'h8000_1234;
        for (int c = 1; c <= 5; c++) begin
            tick();
            exception_type_i = EXC_NO;
            cp0_epc_i = 32'hDEAD_BEEF;
            fetch_ready_i = (c == 4);
            @(negedge clk);
            if (c >= 3) begin
                checks++;
                if (new_pc_o !== 32'h8000_1234) begin
                    errors++;
                    $display("FAIL eret_pc c+%0d: got %h need 80001234", c, new_pc_o);
                end
            end
        end
        checks++;
        if (redirect_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL eret_done: rv=%b busy=%b need 0 0", redirect_valid_o, busy_o);
        end
        fetch_ready_i = 1'b0;
    endtask

    task automatic test_preempt();
        tick();
        exception_type_i = EXC_INVALID_INST;
        tick();
        exception_type_i = EXC_INTERRUPT;   // in FLUSH: ignored
        tick();
        exception_type_i = EXC_NO;
        tick();                             // +3: REDIRECT
        @(negedge clk);
        checks++;
        if (redirect_valid_o !== 1'b1 || new_pc_o !== PC_INVALID_INST) begin
            errors++;
            $display("FAIL preempt_first_redirect: rv=%b pc=%h need 1 %h", redirect_valid_o, new_pc_o, PC_INVALID_INST);
        end
        exception_type_i = EXC_OV;
        fetch_ready_i = 1'b1;
        tick();                             // +4: back in FLUSH
        exception_type_i = EXC_NO;
        fetch_ready_i = 1'b0;
        @(negedge clk);
        checks++;
        if (flush_o !== 1'b1 || redirect_valid_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL preempt_reflush: fl=%b rv=%b busy=%b need 1 0 1", flush_o, redirect_valid_o, busy_o);
        end
        tick();                             // +5: FLUSH
        tick();                             // +6: REDIRECT
        @(negedge clk);
        checks++;
        if (redirect_valid_o !== 1'b1 || new_pc_o !== PC_OV) begin
            errors++;
            $display("FAIL preempt_ov_pc: rv=%b pc=%h need 1 %h", redirect_valid_o, new_pc_o, PC_OV);
        end
        fetch_ready_i = 1'b1;
        tick();
        fetch_ready_i = 1'b0;
    endtask

    task automatic test_tlb_and_reset_drop();
        tick();
        exception_type_i = EXC_DATA_TLB_REFILL;
        tick();
        exception_type_i = EXC_NO;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (redirect_valid_o !== 1'b1 || new_pc_o !== PC_TLB_REFILL) begin
            errors++;
            $display("FAIL tlb_refill_pc: rv=%b pc=%h need 1 %h", redirect_valid_o, new_pc_o, PC_TLB_REFILL);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (redirect_valid_o !== 1'b0 || busy_o !== 1'b0 || new_pc_o !== PC_RESET_ADDR) begin
            errors++;
            $display("FAIL reset_drops_redirect: rv=%b busy=%b pc=%h", redirect_valid_o, busy_o, new_pc_o);
        end
    endtask

    task automatic test_watchdog();
        logic exp_to;
        tick();
        stallreq_i = 6'b000001;
        for (int e = 1; e <= 8; e++) begin
            tick();
            @(negedge clk);
`ifdef PIPE_CTRL_STALL_WATCHDOG_EN
            exp_to = (e >= 8);
`else
            exp_to = 1'b0;
`endif
            if (e >= 7) begin
                checks++;
                if (stall_timeout_o !== exp_to) begin
                    errors++;
                    $display("FAIL wdog_edge%0d: got %b need %b", e, stall_timeout_o, exp_to);
                end
            end
        end
        stallreq_i = '0;
        tick();
        tick();
        @(negedge clk);
        checks++;
        if (stall_timeout_o !== exp_to) begin
            errors++;
            $display("FAIL wdog_sticky: got %b need %b", stall_timeout_o, exp_to);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (stall_timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL wdog_reset_clear: got %b need 0", stall_timeout_o);
        end
    endtask

    initial begin
        test_reset();
        test_stall_mask();
        test_syscall();
        test_eret();
        test_preempt();
        test_tlb_and_reset_drop();
        test_watchdog();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
